// File: rtl/exp5_unidade_controle_if.sv
// Control/status bundle between the exp5 control unit and its datapath.
// master = control unit (drives controls), slave = datapath side (drives status).
interface exp5_unidade_controle_if;
    logic       iniciar;
    logic       jogada_feita;
    logic       igual;
    logic       fimC;
    logic       zeraC;
    logic       contaC;
    logic       zeraR;
    logic       registraR;
    logic       pronto;
    logic       acertou;
    logic       errou;
    logic       timeout;
    logic [3:0] db_estado;

    // Handshake: jogada_feita is a one-cycle pulse; it is consumed only in ESPERA,
    // there is no ready/back-pressure, and a pulse seen in any other state is dropped.
    modport master (
        input  iniciar, jogada_feita, igual, fimC,
        output zeraC, contaC, zeraR, registraR,
        output pronto, acertou, errou, timeout, db_estado
    );

    modport slave (
        output iniciar, jogada_feita, igual, fimC,
        input  zeraC, contaC, zeraR, registraR,
        input  pronto, acertou, errou, timeout, db_estado
    );
endinterface

// File: rtl/exp5_unidade_controle.sv
// Moore control unit for the exp5 memory game: clears, waits for plays, latches,
// compares against the pattern ROM and advances; ends in win, lose or timeout.
module exp5_unidade_controle #(
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int CNT_WIDTH      = 16
) (
    input logic                    clock,
    input logic                    reset,
    exp5_unidade_controle_if.master bus
);

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARA     = 4'h1,
        ESPERA      = 4'h2,
        REGISTRA    = 4'h4,
        COMPARA     = 4'h5,
        PROXIMO     = 4'h6,
        FIM_ACERTO  = 4'hA,
        FIM_TIMEOUT = 4'hD,
        FIM_ERRO    = 4'hE
    } state_t;

    localparam bit                   TMO_EN   = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_WIDTH-1:0] TMO_LAST = TMO_EN ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

    state_t               state;
    state_t               next_state;
    logic [CNT_WIDTH-1:0] tmo_cnt;
    logic                 tmo_hit;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= INICIAL;
        end else begin
            state <= next_state;
        end
    end

    // Counts consecutive ESPERA cycles without a play; saturates instead of wrapping.
    always_ff @(posedge clock) begin
        if (!reset) begin
            tmo_cnt <= '0;
        end else if (!TMO_EN || state != ESPERA || bus.jogada_feita) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign tmo_hit = TMO_EN && (state == ESPERA) && (tmo_cnt == TMO_LAST);

    always_comb begin
        next_state = state;
        case (state)
            INICIAL:     if (bus.iniciar) next_state = PREPARA;
            PREPARA:     next_state = ESPERA;
            // A play arriving on the expiry cycle takes priority over the timeout.
            ESPERA: begin
                if (bus.jogada_feita) next_state = REGISTRA;
                else if (tmo_hit)     next_state = FIM_TIMEOUT;
            end
            REGISTRA:    next_state = COMPARA;
            COMPARA: begin
                if (!bus.igual)    next_state = FIM_ERRO;
                else if (bus.fimC) next_state = FIM_ACERTO;
                else               next_state = PROXIMO;
            end
            PROXIMO:     next_state = ESPERA;
            FIM_ACERTO,
            FIM_ERRO,
            FIM_TIMEOUT: if (bus.iniciar) next_state = PREPARA;
            default:     next_state = INICIAL;
        endcase
    end

    always_comb begin
        bus.zeraC     = 1'b0;
        bus.contaC    = 1'b0;
        bus.zeraR     = 1'b0;
        bus.registraR = 1'b0;
        bus.pronto    = 1'b0;
        bus.acertou   = 1'b0;
        bus.errou     = 1'b0;
        bus.timeout   = 1'b0;
        bus.db_estado = state;
        case (state)
            PREPARA: begin
                bus.zeraC = 1'b1;
                bus.zeraR = 1'b1;
            end
            REGISTRA:    bus.registraR = 1'b1;
            PROXIMO:     bus.contaC    = 1'b1;
            FIM_ACERTO: begin
                bus.pronto  = 1'b1;
                bus.acertou = 1'b1;
            end
            FIM_ERRO: begin
                bus.pronto = 1'b1;
                bus.errou  = 1'b1;
            end
            FIM_TIMEOUT: begin
                bus.pronto  = 1'b1;
                bus.timeout = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_exp5_unidade_controle.sv
// Directed bench for exp5_unidade_controle with a small behavioural datapath
// (address counter, play register, pattern ROM) closing the loop.
module tb_exp5_unidade_controle;

    logic clock;
    logic reset;
    logic [3:0] play_val;
    logic [3:0] addr;
    logic [3:0] play_reg;
    int errors;
    int checks;
    int conta_count;

    logic [3:0] rom [0:15] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd4, 4'd2, 4'd1, 4'd1,
                               4'd2, 4'd2, 4'd4, 4'd4, 4'd8, 4'd8, 4'd1, 4'd4};

    // Expected {zeraC,contaC,zeraR,registraR,pronto,acertou,errou,timeout} per state
    localparam logic [7:0] O_IDLE = 8'b0000_0000;
    localparam logic [7:0] O_PREP = 8'b1010_0000;
    localparam logic [7:0] O_REG  = 8'b0001_0000;
    localparam logic [7:0] O_NEXT = 8'b0100_0000;
    localparam logic [7:0] O_WIN  = 8'b0000_1100;
    localparam logic [7:0] O_LOSE = 8'b0000_1010;
    localparam logic [7:0] O_TMO  = 8'b0000_1001;

    exp5_unidade_controle_if bus ();

    exp5_unidade_controle #(.TIMEOUT_CYCLES(20), .CNT_WIDTH(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // behavioural datapath
    always @(posedge clock) begin
        if (bus.zeraC)       addr <= 4'd0;
        else if (bus.contaC) addr <= addr + 4'd1;
        if (bus.zeraR)          play_reg <= 4'd0;
        else if (bus.registraR) play_reg <= play_val;
    end

    assign bus.igual = (rom[addr] == play_reg);
    assign bus.fimC  = (addr == 4'd15);

    wire [7:0] outs = {bus.zeraC, bus.contaC, bus.zeraR, bus.registraR,
                       bus.pronto, bus.acertou, bus.errou, bus.timeout};

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (bus.contaC) conta_count++;
    endtask

    task automatic start();
        bus.iniciar = 1'b1;
        tick();
        bus.iniciar = 1'b0;
        conta_count = 0;
    endtask

    task automatic play_step(input logic [3:0] v);
        play_val = v;
        bus.jogada_feita = 1'b1;
        tick();
        bus.jogada_feita = 1'b0;
    endtask

    // Advance until the FSM rests in ESPERA or a terminal state.
    task automatic settle();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 4 && !done; k++) begin
            tick();
            if (bus.db_estado inside {4'h2, 4'hA, 4'hE, 4'hD}) done = 1'b1;
        end
        if (!done) check_eq("settle_bound", bus.db_estado, 16'h2);
    endtask

    task automatic wait_ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        conta_count = 0;
        play_val = 4'd0;
        addr = 4'd0;
        play_reg = 4'd0;
        reset = 1'b0;
        bus.iniciar = 1'b0;
        bus.jogada_feita = 1'b0;

        // reset state
        wait_ticks(2);
        check_eq("rst_state", bus.db_estado, 16'h0);
        check_eq("rst_outs", outs, O_IDLE);
        reset = 1'b1;
        wait_ticks(2);
        check_eq("idle_hold", bus.db_estado, 16'h0);

        // full win
        start();
        check_eq("win_prep_state", bus.db_estado, 16'h1);
        check_eq("win_prep_outs", outs, O_PREP);
        tick();
        check_eq("win_espera", bus.db_estado, 16'h2);
        play_step(rom[0]);
        check_eq("win_reg_state", bus.db_estado, 16'h4);
        check_eq("win_reg_outs", outs, O_REG);
        tick();
        check_eq("win_cmp_state", bus.db_estado, 16'h5);
        tick();
        check_eq("win_next_outs", outs, O_NEXT);
        tick();
        check_eq("win_back_espera", bus.db_estado, 16'h2);
        for (int i = 1; i < 16; i++) begin
            play_step(rom[i]);
            settle();
        end
        check_eq("win_state", bus.db_estado, 16'hA);
        check_eq("win_outs", outs, O_WIN);
        check_eq("win_contac", conta_count[15:0], 16'd15);
        tick();
        check_eq("win_hold", bus.db_estado, 16'hA);

        // error: plays 1,2 then 8 where 4 is expected
        start();
        check_eq("err_prep_outs", outs, O_PREP);
        tick();
        play_step(4'd1); settle();
        play_step(4'd2); settle();
        play_step(4'd8);
        check_eq("err_reg", bus.db_estado, 16'h4);
        tick();
        check_eq("err_cmp", bus.db_estado, 16'h5);
        tick();
        check_eq("err_state", bus.db_estado, 16'hE);
        check_eq("err_outs", outs, O_LOSE);
        check_eq("err_contac", conta_count[15:0], 16'd2);

        // restart with iniciar held from FIM_ERRO; ignored in PREPARA/ESPERA
        bus.iniciar = 1'b1;
        tick();
        check_eq("rs_prep_state", bus.db_estado, 16'h1);
        check_eq("rs_prep_outs", outs, O_PREP);
        tick();
        check_eq("rs_espera", bus.db_estado, 16'h2);
        check_eq("rs_espera_outs", outs, O_IDLE);
        wait_ticks(3);
        check_eq("rs_ini_ignored", bus.db_estado, 16'h2);
        bus.iniciar = 1'b0;
        play_step(4'd1);
        check_eq("rs_play_taken", bus.db_estado, 16'h4);
        settle();

        // drive back into a terminal state to restart cleanly: wrong play
        play_step(4'd8); settle();
        check_eq("rs_lose_again", bus.db_estado, 16'hE);

        // timeout: exactly 20 ESPERA cycles
        start();
        tick();
        wait_ticks(19);
        check_eq("tmo_not_yet", bus.db_estado, 16'h2);
        tick();
        check_eq("tmo_state", bus.db_estado, 16'hD);
        check_eq("tmo_outs", outs, O_TMO);

        // play on the expiry cycle wins; counter restarts on next ESPERA
        start();
        tick();
        wait_ticks(19);
        play_step(4'd1);
        check_eq("tmo_play_wins", bus.db_estado, 16'h4);
        settle();
        check_eq("tmo_back_espera", bus.db_estado, 16'h2);
        wait_ticks(19);
        check_eq("tmo_restart_wait", bus.db_estado, 16'h2);
        tick();
        check_eq("tmo_restart_fire", bus.db_estado, 16'hD);

        // jogada_feita during PROXIMO is dropped
        start();
        tick();
        play_step(4'd1);
        tick();
        tick();
        check_eq("ign_in_next", bus.db_estado, 16'h6);
        play_step(4'd2);
        check_eq("ign_espera", bus.db_estado, 16'h2);
        wait_ticks(3);
        check_eq("ign_dropped", bus.db_estado, 16'h2);
        check_eq("ign_addr", addr, 16'd1);

        // reset mid-game during REGISTRA at address 5
        for (int i = 1; i < 5; i++) begin
            play_step(rom[i]);
            settle();
        end
        check_eq("mid_addr5", addr, 16'd5);
        play_step(rom[5]);
        check_eq("mid_reg", bus.db_estado, 16'h4);
        reset = 1'b0;
        tick();
        check_eq("mid_rst_state", bus.db_estado, 16'h0);
        check_eq("mid_rst_outs", outs, O_IDLE);
        reset = 1'b1;
        wait_ticks(2);
        check_eq("mid_idle", bus.db_estado, 16'h0);
        check_eq("mid_addr_kept", addr, 16'd5);
        start();
        tick();
        check_eq("mid_addr_cleared", addr, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exp5_unidade_controle.md
# exp5_unidade_controle

Moore control unit that sequences the exp5 game datapath (address counter, play register, pattern ROM, comparator, play edge detector). It clears the datapath on start, waits for each play, latches it, compares it against the stored pattern entry, and advances the address. It ends in one of three terminal states: win, lose or timeout. It sits beside the datapath in the exp5 top level; its outputs drive the datapath control inputs directly, and datapath status returns as its inputs.

## Interface
- TIMEOUT_CYCLES, 5000: cycles allowed in ESPERA before timeout; 0 disables timeout; must be < 2^CNT_WIDTH.
- CNT_WIDTH, 16: width of the internal timeout counter.

- clock  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-low (asserted when 0, sampled on rising edge of clock).
- iniciar  in  1  start/restart request, level-sampled.
- jogada_feita  in  1  one-cycle play pulse from the datapath edge detector.
- igual  in  1  comparator equal (ROM data == registered play).
- fimC  in  1  counter RCO (address == 15).
- zeraC  out  1  clear address counter and edge detector.
- contaC  out  1  increment address counter.
- zeraR  out  1  clear play register.
- registraR  out  1  load play register.
- pronto  out  1  in any terminal state.
- acertou  out  1  terminal win.
- errou  out  1  terminal lose.
- timeout  out  1  terminal timeout.
- db_estado  out  4  current state code.

## Operation
- States and db_estado codes: INICIAL 0x0, PREPARA 0x1, ESPERA 0x2, REGISTRA 0x4, COMPARA 0x5, PROXIMO 0x6, FIM_ACERTO 0xA, FIM_ERRO 0xE, FIM_TIMEOUT 0xD. Unused codes go to INICIAL.
- Outputs are decoded from the state register only (Moore), with no input-to-output combinational path.
- INICIAL: all outputs 0. Goes to PREPARA when iniciar=1; otherwise stays.
- PREPARA: zeraC=1, zeraR=1 for exactly one cycle, then goes to ESPERA.
- ESPERA: all controls 0. Goes to REGISTRA when jogada_feita=1. Goes to FIM_TIMEOUT when the timeout counter reaches TIMEOUT_CYCLES-1 and jogada_feita=0. Otherwise stays.
- REGISTRA: registraR=1 for one cycle, then goes to COMPARA.
- COMPARA: all controls 0.
  - igual=0: goes to FIM_ERRO.
  - igual=1 and fimC=1: goes to FIM_ACERTO.
  - igual=1 and fimC=0: goes to PROXIMO.
- PROXIMO: contaC=1 for one cycle, then goes to ESPERA.
- FIM_ACERTO: pronto=1, acertou=1. FIM_ERRO: pronto=1, errou=1. FIM_TIMEOUT: pronto=1, timeout=1.
- Terminal states hold until iniciar=1, then go to PREPARA. Restart requires no pass through INICIAL.
- Timeout counter:
  - Cleared to 0 in every state except ESPERA, and on the cycle jogada_feita=1.
  - Increments by 1 each ESPERA cycle.
  - Saturates and never wraps.
  - Held at 0 when TIMEOUT_CYCLES=0.
- iniciar is ignored in PREPARA, ESPERA, REGISTRA, COMPARA and PROXIMO.
- jogada_feita is ignored outside ESPERA. A pulse arriving in REGISTRA, COMPARA or PROXIMO is dropped, not queued.

## Timing
- Reset (reset=0 at a rising edge): next state is INICIAL, timeout counter is 0, and every output is 0, including db_estado=0x0.
- Reset overrides all inputs, including in mid-game.
- Reset does not drive zeraC or zeraR. The datapath is cleared only by the next PREPARA.
- Play latency: jogada_feita sampled high in ESPERA at edge N gives registraR=1 during cycle N..N+1 and COMPARA during N+1..N+2. The decision takes effect at edge N+2.
- In COMPARA, the ROM output (synchronous) and the register output are both valid:
  - The address has been stable for at least 2 cycles since PROXIMO.
  - The register was loaded at the end of REGISTRA.
- Total game = 16 matched plays. The 16th COMPARA sees fimC=1 because the address equals 15.
- Simultaneous jogada_feita=1 and timeout expiry in ESPERA: jogada_feita wins, and the next state is REGISTRA.
- Timeout fires after exactly TIMEOUT_CYCLES consecutive ESPERA cycles without a play, counting from ESPERA entry.

## Test plan
- Full win:
  - Stimulus: reset, iniciar, then 16 plays matching ROM sequence 1,2,4,8,4,2,1,1,2,2,4,4,8,8,1,4.
  - Required: contaC pulses exactly 15 times; final state FIM_ACERTO; pronto=1, acertou=1; db_estado=0xA.
- Error:
  - Stimulus: plays 1,2 then 8 at address 2 (expected 4).
  - Required: FIM_ERRO two cycles after the third jogada_feita; errou=1; db_estado=0xE; contaC count = 2.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=20; after start, no play.
  - Required: FIM_TIMEOUT exactly 20 cycles after ESPERA entry.
  - Second stimulus: a play at cycle 19 of the wait.
  - Required: no timeout; counter restarts at the next ESPERA.
- Restart:
  - Stimulus: iniciar held in FIM_ERRO.
  - Required: PREPARA with zeraC=1, zeraR=1 for one cycle, then ESPERA; acertou=errou=timeout=pronto=0.
- Reset mid-game:
  - Stimulus: reset=0 during REGISTRA at address 5.
  - Required: INICIAL next edge, all outputs 0, zeraC=0; address 5 stays until the next PREPARA.
- Ignored inputs:
  - Stimulus: iniciar=1 in ESPERA; jogada_feita in PROXIMO.
  - Required: no state change attributable to either input; exactly one play consumed per ESPERA visit.
